// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master and slave endpoints.
// Holds the default frame width, the frame FSM states and the counter-width helper.
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  function automatic int spi_cnt_width(input int data_width);
    return $clog2(data_width) + 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage pin synchronizer with one-cycle rise/fall pulses on the synchronized value.
// Latency STAGES clk from pin to pulse; no backpressure, pulses are never held.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;
  logic              q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave endpoint (CPOL=0, LSB first) oversampling sclk/cs_n/mosi in the clk domain.
// Pin-to-action latency SYNC_STAGES+1 clk; tx holding register refuses loads until consumed by a frame.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  rx_ack
);

  localparam int CW = spi_cnt_width(DATA_WIDTH);

  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;
  logic mosi_s;

  logic [SYNC_STAGES-1:0] mosi_sync;

  spi_state_e state;
  spi_state_e nxt_state;

  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] nxt_hold;
  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] nxt_sh;
  logic [DATA_WIDTH-1:0] nxt_rx_data;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         nxt_cnt;

  logic nxt_tx_ready;
  logic nxt_miso;
  logic nxt_miso_oe;
  logic nxt_busy;
  logic nxt_rx_valid;
  logic rx_pending;
  logic nxt_rx_pending;
  logic nxt_overrun;
  logic consume;
  logic frame_done;

  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cs_n),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // mosi only needs the same delay as sclk so it is sampled aligned with sclk_fall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mosi_sync <= '0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state      = state;
    nxt_hold       = hold;
    nxt_sh         = sh;
    nxt_cnt        = cnt;
    nxt_tx_ready   = tx_ready;
    nxt_miso       = miso;
    nxt_miso_oe    = miso_oe;
    nxt_busy       = busy;
    nxt_rx_data    = rx_data;
    nxt_rx_valid   = 1'b0;
    nxt_rx_pending = rx_pending;
    nxt_overrun    = overrun;
    consume        = 1'b0;
    frame_done     = 1'b0;

    case (state)
      IDLE: begin
        // a coincident sclk rise is dropped: the master violated setup
        if (cs_fall) begin
          nxt_sh      = hold;
          consume     = 1'b1;
          nxt_cnt     = '0;
          nxt_busy    = 1'b1;
          nxt_miso_oe = 1'b1;
          nxt_miso    = 1'b0;
          nxt_state   = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          nxt_state   = IDLE;
          nxt_miso_oe = 1'b0;
          nxt_miso    = 1'b0;
          nxt_busy    = 1'b0;
          nxt_cnt     = '0;
        end else if (sclk_rise) begin
          nxt_miso = sh[0];
          nxt_sh   = {1'b0, sh[DATA_WIDTH-1:1]};
        end else if (sclk_fall) begin
          if (cnt == CW'(DATA_WIDTH - 1)) begin
            frame_done   = 1'b1;
            nxt_rx_data  = {mosi_s, sh[DATA_WIDTH-2:0]};
            nxt_rx_valid = 1'b1;
            nxt_cnt      = '0;
            nxt_sh       = hold;
            consume      = 1'b1;
          end else begin
            nxt_sh  = {mosi_s, sh[DATA_WIDTH-2:0]};
            nxt_cnt = cnt + CW'(1);
          end
        end
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase

    // Consumed holding register reads as zero so an unloaded frame shifts out zeros.
    if (consume) begin
      nxt_hold     = '0;
      nxt_tx_ready = 1'b1;
    end
    if (tx_load && tx_ready) begin
      nxt_hold     = tx_data;
      nxt_tx_ready = 1'b0;
    end

    if (rx_ack) begin
      nxt_rx_pending = 1'b0;
      nxt_overrun    = 1'b0;
    end
    if (frame_done) begin
      nxt_rx_pending = 1'b1;
      if (rx_pending && !rx_ack) begin
        nxt_overrun = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold       <= '0;
      sh         <= '0;
      cnt        <= '0;
      tx_ready   <= 1'b1;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      busy       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_pending <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      hold       <= nxt_hold;
      sh         <= nxt_sh;
      cnt        <= nxt_cnt;
      tx_ready   <= nxt_tx_ready;
      miso       <= nxt_miso;
      miso_oe    <= nxt_miso_oe;
      busy       <= nxt_busy;
      rx_data    <= nxt_rx_data;
      rx_valid   <= nxt_rx_valid;
      rx_pending <= nxt_rx_pending;
      overrun    <= nxt_overrun;
    end
  end

endmodule
